// File: rtl/mp4_tag_sram_if.sv
// Port bundle for mp4_tag_sram: read/write port 0, read-only port 1 and the ready flag.
interface mp4_tag_sram_if #(
    parameter int DATA_WIDTH = 23,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 3
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  ready;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout1, ready
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout1, ready
    );
endinterface

// File: rtl/mp4_tag_sram.sv
// Behavioural 1RW + 1R SRAM for cache tag/valid/dirty arrays, with a reset-driven init sweep.
// Optional macro SRAM_BYPASS_EN: port 1 sees port 0's merged write data on a same-address collision.
module mp4_tag_sram #(
    parameter int                    DATA_WIDTH = 23,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    WMASK_GRAN = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input logic           clk0,
    input logic           rst0,
    mp4_tag_sram_if.slave bus
);
    localparam int                    RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int                    NUM_WMASKS = (DATA_WIDTH + WMASK_GRAN - 1) / WMASK_GRAN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Widen the per-group write mask into a per-bit mask; the last group may be partial.
    function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [NUM_WMASKS-1:0] m);
        logic [DATA_WIDTH-1:0] b;
        b = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b[i] = m[i / WMASK_GRAN];
        end
        return b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [DATA_WIDTH-1:0] bmask);
        return (old_w & ~bmask) | (new_w & bmask);
    endfunction

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] dout0_r;
    logic [DATA_WIDTH-1:0] dout1_r;
    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

    logic                  p0_rd_s;
    logic                  p0_wr_s;
    logic                  p1_rd_s;
    logic [DATA_WIDTH-1:0] bit_mask_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] rd1_data_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    assign bus.dout0 = dout0_r;
    assign bus.dout1 = dout1_r;
    assign bus.ready = ready_r;

    // Decode port requests; nothing is accepted until the sweep has finished.
    always_comb begin
        p0_rd_s    = (state_r == ST_READY) && !bus.csb0 && bus.web0;
        p0_wr_s    = (state_r == ST_READY) && !bus.csb0 && !bus.web0;
        p1_rd_s    = (state_r == ST_READY) && !bus.csb1;
        bit_mask_s = expand_mask(bus.wmask0);
        merged_s   = merge_word(mem_r[bus.addr0], bus.din0, bit_mask_s);
    end

    // Port 1 read data, read-first unless bypass of a colliding write is enabled.
    always_comb begin
        rd1_data_s = mem_r[bus.addr1];
`ifdef SRAM_BYPASS_EN
        if (p0_wr_s && (bus.addr0 == bus.addr1)) begin
            rd1_data_s = merged_s;
        end else begin
            rd1_data_s = mem_r[bus.addr1];
        end
`else
        rd1_data_s = mem_r[bus.addr1];
`endif
    end

    // Select the single array write source: init sweep or masked port 0 write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_r;
        mem_wdata_s = INIT_VALUE;
        if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = INIT_VALUE;
        end else if (p0_wr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.addr0;
            mem_wdata_s = merged_s;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array; every entry is rewritten by the sweep, so it needs no reset.
    always_ff @(posedge clk0) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Init/ready FSM with registered read outputs.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_r <= ST_INIT;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
            ready_r <= 1'b0;
            dout0_r <= {DATA_WIDTH{1'b0}};
            dout1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + ADDR_WIDTH'(1);
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                        ready_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (p0_rd_s) begin
                        dout0_r <= mem_r[bus.addr0];
                    end
                    if (p1_rd_s) begin
                        dout1_r <= rd1_data_s;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    cnt_r   <= {ADDR_WIDTH{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mp4_tag_sram.md
# mp4_tag_sram

Parametrised behavioural SRAM model for cache tag/valid/dirty arrays, succeeding the fixed-size single-port tag array model. It provides one read/write port with a masked write and one read-only port, so lookup and fill/writeback paths can share an array. A reset-driven initialisation sweep writes `INIT_VALUE` into every entry before accesses are accepted, which removes the X-valid bits that the old model left after power-up. All arrays instantiate it from the cache datapath, with parameters chosen per array.

## Interface
- `DATA_WIDTH`, 23: word width in bits.
- `ADDR_WIDTH`, 4: address width; `RAM_DEPTH = 1 << ADDR_WIDTH`.
- `WMASK_GRAN`, 8: bits per write-mask group; `NUM_WMASKS = ceil(DATA_WIDTH / WMASK_GRAN)`.
- `INIT_VALUE`, 0: value written to every entry by the init sweep (`DATA_WIDTH` bits).

Ports:
- `clk0`  in  1  clock; all state changes on posedge. One clock.
- `rst0`  in  1  reset; asynchronous, active-high.
- `csb0`  in  1  port 0 chip select, active low.
- `web0`  in  1  port 0 write enable, active low.
- `wmask0`  in  NUM_WMASKS  port 0 write mask; bit i covers data bits [i*WMASK_GRAN, min((i+1)*WMASK_GRAN, DATA_WIDTH)-1].
- `addr0`  in  ADDR_WIDTH  port 0 address.
- `din0`  in  DATA_WIDTH  port 0 write data.
- `dout0`  out  DATA_WIDTH  port 0 read data.
- `csb1`  in  1  port 1 chip select, active low (read-only port).
- `addr1`  in  ADDR_WIDTH  port 1 address.
- `dout1`  out  DATA_WIDTH  port 1 read data.
- `ready`  out  1  high once the init sweep is complete; accesses are accepted only while high.

## Operation
- The FSM has two states, INIT and READY. While `rst0` is high the block is held in INIT with the sweep counter at 0.
- INIT: each posedge writes `INIT_VALUE` to `mem[cnt]` and increments `cnt`. The edge that writes entry `RAM_DEPTH-1` moves the FSM to READY and sets `ready=1`. Port inputs are ignored in INIT, and `dout0`/`dout1` hold 0.
- READY: the FSM stays here until `rst0` is asserted. There is no other exit.
- Port 0 write (`csb0=0`, `web0=0`): only mask groups with `wmask0[i]=1` are updated. An all-zero mask is a no-op write.
- Port 0 write cycle: `dout0` holds its previous value.
- Port 0 read (`csb0=0`, `web0=1`): `dout0` gets `mem[addr0]`.
- Port 1 read (`csb1=0`): `dout1` gets `mem[addr1]`.
- Deselected port (`csb=1`): its dout holds its previous value.
- Both ports reading the same address: both return the same data.
- Port 1 reads address A while port 0 writes A in the same cycle: `dout1` returns the pre-write word (read-first), unless `SRAM_BYPASS_EN` is defined (see Configuration).
- `rst0` asserted at any time, including mid-sweep or mid-access: the sweep restarts from entry 0 after deassertion, and memory contents are fully rewritten.
- `addr` widths exactly cover `RAM_DEPTH`, so no out-of-range case exists.

## Timing
- Reset values: `ready=0`, `dout0=0`, `dout1=0`, FSM=INIT, `cnt=0`.
- Init latency: `ready` rises on the `RAM_DEPTH`-th posedge after `rst0` deasserts. For example, with depth 16, `ready` rises on edge 16.
- Inputs are sampled at posedge k only if `ready` was 1 before that edge.
- Write: committed at posedge k and visible to any read sampled at posedge k+1.
- Read latency is 1: the data appears on dout after posedge k and stays stable until the next selected read on that port.
- Back-to-back accesses on both ports are supported every cycle; there are no stall cycles.

## Configuration
- Macro: `SRAM_BYPASS_EN`.
- Defined: on a same-cycle port 0 write and port 1 read to the same address, `dout1` returns the merged word: new data in masked groups, old data in unmasked groups.
- Undefined: `dout1` returns the old word (read-first).
- No other behaviour differs.

## Test plan
- Reset release with `INIT_VALUE=0x7FFFFF` and depth 16 -> `ready` rises exactly at edge 16; reads of addresses 0..15 on both ports return `0x7FFFFF`, and `dout0`/`dout1` are 0 before that.
- Accesses during INIT: a write of `0x123456` to addr 3 at edge 5 is ignored -> after `ready`, addr 3 reads the init value.
- Masked write with `WMASK_GRAN=8`: write `0x7FFFFF` with `wmask0=3'b101` over stored 0 -> readback `0x7F00FF`. A subsequent `wmask0=0` write leaves it unchanged.
- Same-cycle collision: addr 9 holds `0x000011`; port 0 writes `0x0000AA` (all mask bits set) while port 1 reads addr 9 -> `dout1=0x000011` without the macro, `0x0000AA` with it. The next-cycle read returns `0x0000AA` in both builds.
- Hold behaviour: after a port 0 read of addr 2 returns X, a `csb0=1` cycle and a port 0 write cycle -> `dout0` still equals X.
- Reset mid-sweep: assert `rst0` at init edge 7 -> `ready` and both dout go to 0 immediately; after deassertion `ready` rises after a full 16 edges.
